// File: rtl/uart_fast_write.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | uart_fast_write: FIFO-buffered serializer, 12-bit frames                    |
// | (guard, start, 8 data LSB first, even parity, stop). Revision 1.0           |
// +-----------------------------------------------------------------------------+
module uart_fast_write #(
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] word,
  input  logic       write,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       uart_stream
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   c_DEPTH    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] c_CYC_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GUARD  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_parity;
  logic [2:0]    r_bit;
  logic [CW-1:0] r_cyc;
  logic          r_line;
  logic          w_line_nxt;
  logic          r_overflow;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_bit_done;

  assign w_full     = (r_count == c_DEPTH);
  assign w_bit_done = (r_cyc == c_CYC_LAST);
  // A full FIFO still accepts a write when the serializer frees a slot in the same cycle.
  assign w_push     = write && (!w_full || w_pop);

  assign full        = w_full;
  assign overflow    = r_overflow;
  assign busy        = (r_state != S_IDLE) || (r_count != '0);
  assign uart_stream = r_line;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift_nxt = r_shift;
    w_line_nxt  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_GUARD;
        end
      end
      S_GUARD:  if (w_bit_done) w_state_nxt = S_START;
      S_START:  if (w_bit_done) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_bit_done) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: if (w_bit_done) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_bit_done) begin
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = S_GUARD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_pop) w_shift_nxt = r_mem[r_rptr];
    // The line register is loaded with the level belonging to the upcoming state.
    case (w_state_nxt)
      S_START:  w_line_nxt = 1'b0;
      S_DATA:   w_line_nxt = w_shift_nxt[0];
      S_PARITY: w_line_nxt = r_parity;
      default:  w_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_bit      <= '0;
      r_cyc      <= '0;
      r_line     <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_line     <= w_line_nxt;
      r_overflow <= write && !w_push;
      if (w_pop) r_parity <= ^r_mem[r_rptr];
      if (r_state == S_IDLE || w_bit_done) r_cyc <= '0;
      else                                 r_cyc <= r_cyc + 1'b1;
      if (r_state == S_START)                   r_bit <= '0;
      else if (r_state == S_DATA && w_bit_done) r_bit <= r_bit + 3'd1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
